draw_sequencer: RTL and testbench
=================================

Name: draw_sequencer

Overview:
- Parametrised frame sequencer and pixel-stream arbiter for the VGA draw path.
- Serves NCH draw engines (ball, bricks, platform, future sprites) and drives the single pixel write port.
- Each frame: erase pass over enabled channels, game-logic step pulse with settle window, then paint pass.
- Channels finish with a done handshake. A timeout budget protects against a hung engine, and a one-deep pending frame request is held.

Parameters:
- NCH, 3, number of draw channels; channel 0 is serviced first.
- XW, 10, x coordinate width.
- YW, 10, y coordinate width.
- CW, 3, colour width.
- BG_COLOUR, 3'b000, colour substituted during the erase pass.
- TIMEOUT, 4095, maximum DRAW cycles per channel before forced advance.
- LOGIC_CYCLES, 12, settle cycles after logic_go before the paint pass starts.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- reset  in  1  asynchronous, active-high reset.
- frame_tick  in  1  one-cycle frame request from delay_counter.
- ch_mask  in  NCH  channel enable; sampled at frame start.
- ch_x  in  NCH*XW  packed channel x; channel i at [i*XW +: XW].
- ch_y  in  NCH*YW  packed channel y.
- ch_colour  in  NCH*CW  packed channel colour.
- ch_wren  in  NCH  per-channel pixel write strobe.
- ch_done  in  NCH  per-channel completion pulse or level.
- ch_go  out  NCH  one-hot, one-cycle start pulse to a channel.
- logic_go  out  1  one-cycle game-logic step pulse.
- erase  out  1  high throughout the erase pass.
- x  out  XW  muxed pixel x.
- y  out  YW  muxed pixel y.
- colour  out  CW  muxed pixel colour.
- writeEn  out  1  muxed pixel write.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  sticky; set when any channel times out.
- overrun_err  out  1  sticky; set when a frame_tick arrives while a pending request is already held.

Behaviour:
- Reset (async, active-high):
  - State IDLE.
  - All outputs 0; ch_go = 0.
  - pending, both error flags, counters and mask latch cleared.
  - Reset mid-pass aborts immediately. No residual writeEn or ch_go is emitted after reset deasserts.
- States: IDLE, ERASE_SEL, ERASE_GO, ERASE_DRAW, LOGIC, LOGIC_WAIT, PAINT_SEL, PAINT_GO, PAINT_DRAW.
- Frame start:
  - IDLE moves to ERASE_SEL when frame_tick or pending is set.
  - On that transition: latch ch_mask, clear pending, set ch_idx = 0.
- Pass selection (x_SEL):
  - Scan from ch_idx to the lowest index >= ch_idx with its latched mask bit set.
  - The scan is combinational priority within one cycle.
  - If a channel is found, go to x_GO with ch_idx set to that channel.
  - If none: ERASE_SEL goes to LOGIC; PAINT_SEL goes to IDLE.
- x_GO: lasts 1 cycle.
  - ch_go[ch_idx] = 1.
  - Timeout counter cleared.
  - Next state is x_DRAW.
- x_DRAW:
  - Counter increments each cycle.
  - Exit on ch_done[ch_idx] = 1, or when counter == TIMEOUT (on timeout, set timeout_err).
  - On exit: ch_idx = ch_idx + 1, go to x_SEL.
  - If ch_idx was NCH-1, x_SEL finds no channel (no wrap).
  - ch_done is ignored outside x_DRAW and for non-current channels.
- Output mux:
  - In x_GO and x_DRAW: x, y, writeEn come from channel ch_idx.
  - colour = erase ? BG_COLOUR : ch_colour[ch_idx].
  - In all other states: writeEn = 0; x, y, colour hold channel 0 values (don't-care).
- erase = 1 in ERASE_SEL, ERASE_GO and ERASE_DRAW; 0 elsewhere.
- LOGIC: lasts 1 cycle; logic_go = 1; counter cleared; next state LOGIC_WAIT.
- LOGIC_WAIT:
  - Exit after LOGIC_CYCLES cycles (counter == LOGIC_CYCLES-1) to PAINT_SEL with ch_idx = 0.
  - If LOGIC_CYCLES = 0, go straight to PAINT_SEL.
- Frame ticks while busy:
  - frame_tick while busy and pending = 0 sets pending.
  - frame_tick while pending = 1 sets overrun_err; the extra tick is dropped.
  - A tick in the same cycle as the PAINT_SEL to IDLE transition sets pending.
- Errors clear only on reset.
- Mask changes mid-frame have no effect until the next frame start.
- Timeout counter width is clog2(max(TIMEOUT, LOGIC_CYCLES)+1).

Test Plan:
- NCH=3, mask=3'b111, each channel raises done 4 cycles after its go:
  - ch_go pulses in order 0,1,2 with erase=1, then logic_go, then 12 cycles later 0,1,2 with erase=0.
  - Colour during erase is 3'b000 even when ch_colour = 3'b111.
  - Then IDLE, busy=0.
- mask=3'b101: channel 1 never receives ch_go in either pass; ch_go[2] follows channel 0's done within 2 cycles.
- mask=0: frame_tick yields logic_go only; busy returns low after 1+12+2 cycles; writeEn never asserted.
- Channel 1 never asserts done, TIMEOUT=16: DRAW lasts exactly 17 cycles; timeout_err=1; channel 2 is still serviced; flag persists into the next frame.
- Three frame_ticks during one frame: the second sets pending, the third sets overrun_err; exactly one extra frame runs afterwards.
- Assert reset while in PAINT_DRAW with ch_wren=1: writeEn, busy and ch_go drop asynchronously the same cycle; after release, no output activity until the next frame_tick.

Source files
------------

// File: rtl/draw_sequencer.sv
// draw_sequencer: frame sequencer and pixel-stream arbiter for the VGA draw path.
//
// Each frame runs an erase pass over the enabled channels (pixels recoloured to
// BG_COLOUR), issues a one-cycle game-logic step with a settle window, then runs
// a paint pass over the same channels. One channel owns the pixel port at a time.
//
// Handshake: a channel is started by a one-cycle ch_go pulse and owns the pixel
// port from that cycle until the DRAW cycle in which it raises ch_done (pulse or
// level, only sampled for the current channel in DRAW). If it never does, the
// sequencer moves on after TIMEOUT+1 DRAW cycles and sets timeout_err.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   frame_tick          one-cycle frame request (one extra request is queued)
//   ch_mask             channel enables, latched at frame start
//   ch_x/ch_y/ch_colour packed per-channel pixel data, channel i at [i*W +: W]
//   ch_wren, ch_done    per-channel write strobe and completion
//   ch_go               one-hot start pulse
//   logic_go            game-logic step pulse
//   erase               high throughout the erase pass
//   x, y, colour, writeEn  muxed pixel write port
//   busy                high in every state except IDLE
//   timeout_err, overrun_err  sticky error flags, cleared only by reset
module draw_sequencer #(
  parameter int NCH = 3,
  parameter int XW = 10,
  parameter int YW = 10,
  parameter int CW = 3,
  parameter logic [CW-1:0] BG_COLOUR = 3'b000,
  parameter int TIMEOUT = 4095,
  parameter int LOGIC_CYCLES = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_tick,
  input  logic [NCH-1:0]    ch_mask,
  input  logic [NCH*XW-1:0] ch_x,
  input  logic [NCH*YW-1:0] ch_y,
  input  logic [NCH*CW-1:0] ch_colour,
  input  logic [NCH-1:0]    ch_wren,
  input  logic [NCH-1:0]    ch_done,
  output logic [NCH-1:0]    ch_go,
  output logic              logic_go,
  output logic              erase,
  output logic [XW-1:0]     x,
  output logic [YW-1:0]     y,
  output logic [CW-1:0]     colour,
  output logic              writeEn,
  output logic              busy,
  output logic              timeout_err,
  output logic              overrun_err
);

  localparam int CNT_MAX = (TIMEOUT > LOGIC_CYCLES) ? TIMEOUT : LOGIC_CYCLES;
  localparam int CNTW_RAW = $clog2(CNT_MAX + 1);
  localparam int CNTW = (CNTW_RAW < 1) ? 1 : CNTW_RAW;
  // ch_idx must be able to hold NCH (one past the last channel) after the
  // final channel of a pass completes.
  localparam int IW_RAW = $clog2(NCH + 1);
  localparam int IW = (IW_RAW < 1) ? 1 : IW_RAW;
  localparam int LC_LAST = (LOGIC_CYCLES > 0) ? LOGIC_CYCLES - 1 : 0;

  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_ERASE_SEL  = 4'd1;
  localparam logic [3:0] S_ERASE_GO   = 4'd2;
  localparam logic [3:0] S_ERASE_DRAW = 4'd3;
  localparam logic [3:0] S_LOGIC      = 4'd4;
  localparam logic [3:0] S_LOGIC_WAIT = 4'd5;
  localparam logic [3:0] S_PAINT_SEL  = 4'd6;
  localparam logic [3:0] S_PAINT_GO   = 4'd7;
  localparam logic [3:0] S_PAINT_DRAW = 4'd8;

  logic [3:0]      state;
  logic [IW-1:0]   ch_idx;
  logic [CNTW-1:0] cnt;
  logic [NCH-1:0]  mask_q;
  logic            pending;

  logic            found;
  logic [IW-1:0]   sel_idx;
  logic            in_go;
  logic            in_draw;
  logic            cur_done;
  logic [IW-1:0]   mux_idx;

  assign in_go   = (state == S_ERASE_GO) || (state == S_PAINT_GO);
  assign in_draw = (state == S_ERASE_DRAW) || (state == S_PAINT_DRAW);
  assign mux_idx = (in_go || in_draw) ? ch_idx : '0;

  // Lowest enabled channel at or above ch_idx; iterating downwards leaves the
  // lowest match in sel_idx.
  always_comb begin
    found   = 1'b0;
    sel_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask_q[i] && (i >= int'(ch_idx))) begin
        found   = 1'b1;
        sel_idx = IW'(i);
      end
    end
  end

  // Pixel mux and done select. Outside GO/DRAW the index is 0, so x/y/colour
  // show channel 0 and writeEn is forced low.
  always_comb begin
    x        = ch_x[XW-1:0];
    y        = ch_y[YW-1:0];
    colour   = ch_colour[CW-1:0];
    writeEn  = 1'b0;
    cur_done = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (int'(mux_idx) == i) begin
        x        = ch_x[i*XW +: XW];
        y        = ch_y[i*YW +: YW];
        colour   = ch_colour[i*CW +: CW];
        writeEn  = (in_go || in_draw) && ch_wren[i];
        cur_done = ch_done[i];
      end
    end
    if (erase) begin
      colour = BG_COLOUR;
    end
  end

  always_comb begin
    ch_go = '0;
    for (int i = 0; i < NCH; i++) begin
      ch_go[i] = in_go && (int'(ch_idx) == i);
    end
  end

  assign busy     = (state != S_IDLE);
  assign logic_go = (state == S_LOGIC);
  assign erase    = (state == S_ERASE_SEL) || (state == S_ERASE_GO) ||
                    (state == S_ERASE_DRAW);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      ch_idx      <= '0;
      cnt         <= '0;
      mask_q      <= '0;
      pending     <= 1'b0;
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      // Requests arriving mid-frame: queue one, flag anything beyond that.
      if ((state != S_IDLE) && frame_tick) begin
        if (pending) begin
          overrun_err <= 1'b1;
        end else begin
          pending <= 1'b1;
        end
      end

      case (state)
        S_IDLE: begin
          if (frame_tick || pending) begin
            state   <= S_ERASE_SEL;
            mask_q  <= ch_mask;
            pending <= 1'b0;
            ch_idx  <= '0;
          end
        end
        S_ERASE_SEL, S_PAINT_SEL: begin
          if (found) begin
            ch_idx <= sel_idx;
            state  <= (state == S_ERASE_SEL) ? S_ERASE_GO : S_PAINT_GO;
          end else begin
            state  <= (state == S_ERASE_SEL) ? S_LOGIC : S_IDLE;
          end
        end
        S_ERASE_GO, S_PAINT_GO: begin
          cnt   <= '0;
          state <= (state == S_ERASE_GO) ? S_ERASE_DRAW : S_PAINT_DRAW;
        end
        S_ERASE_DRAW, S_PAINT_DRAW: begin
          if (cur_done || (cnt == CNTW'(TIMEOUT))) begin
            if (!cur_done) begin
              timeout_err <= 1'b1;
            end
            ch_idx <= ch_idx + IW'(1);
            state  <= (state == S_ERASE_DRAW) ? S_ERASE_SEL : S_PAINT_SEL;
          end else begin
            cnt <= cnt + CNTW'(1);
          end
        end
        S_LOGIC: begin
          cnt <= '0;
          if (LOGIC_CYCLES == 0) begin
            ch_idx <= '0;
            state  <= S_PAINT_SEL;
          end else begin
            state  <= S_LOGIC_WAIT;
          end
        end
        S_LOGIC_WAIT: begin
          if (cnt == CNTW'(LC_LAST)) begin
            ch_idx <= '0;
            state  <= S_PAINT_SEL;
          end else begin
            cnt <= cnt + CNTW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_draw_sequencer.sv
// tb_draw_sequencer: randomized bench for draw_sequencer.
// A frame-level model turns (start cycle, mask, per-channel done delays) into a
// per-cycle expected waveform plus a queue of expected ch_go/logic_go events.
module tb_draw_sequencer;
  localparam int NCH = 3;
  localparam int XW = 10;
  localparam int YW = 10;
  localparam int CW = 3;
  localparam int TMO = 16;
  localparam int LC = 12;
  localparam int MAXC = 16384;
  localparam int NEVER = 1 << 30;
  localparam logic [CW-1:0] BG = 3'b000;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              frame_tick = 1'b0;
  logic [NCH-1:0]    ch_mask = '0;
  logic [NCH*XW-1:0] ch_x = '0;
  logic [NCH*YW-1:0] ch_y = '0;
  logic [NCH*CW-1:0] ch_colour = '0;
  logic [NCH-1:0]    ch_wren = '0;
  logic [NCH-1:0]    ch_done = '0;
  logic [NCH-1:0]    ch_go;
  logic              logic_go, erase, writeEn, busy, timeout_err, overrun_err;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [CW-1:0]     colour;

  draw_sequencer #(.NCH(NCH), .XW(XW), .YW(YW), .CW(CW), .BG_COLOUR(BG),
                   .TIMEOUT(TMO), .LOGIC_CYCLES(LC)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .ch_mask(ch_mask),
    .ch_x(ch_x), .ch_y(ch_y), .ch_colour(ch_colour), .ch_wren(ch_wren),
    .ch_done(ch_done), .ch_go(ch_go), .logic_go(logic_go), .erase(erase),
    .x(x), .y(y), .colour(colour), .writeEn(writeEn), .busy(busy),
    .timeout_err(timeout_err), .overrun_err(overrun_err)
  );

  // clock
  always #5 clk = ~clk;

  // scoreboard state
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [31:0] exp_q[$];
  int e_own[MAXC];
  bit e_busy[MAXC], e_erase[MAXC], e_go[MAXC], e_done[MAXC];
  bit tk[MAXC], m_set[MAXC];
  logic [NCH-1:0] m_val[MAXC];
  int to_from = NEVER;
  int ov_from = NEVER;
  bit force_col = 1'b0;
  int wren_force_cyc = -1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic clear_model(input int from);
    for (int c = from; c < MAXC; c++) begin
      e_own[c] = -1; e_busy[c] = 0; e_erase[c] = 0; e_go[c] = 0; e_done[c] = 0;
      tk[c] = 0; m_set[c] = 0; m_val[c] = '0;
    end
  endtask

  // Frame model: t0 is the IDLE cycle that accepts the request. Returns the
  // last busy cycle (the final PAINT_SEL).
  function automatic int build_frame(input int t0, input logic [NCH-1:0] m, input int dl[2][NCH]);
    int t, ex;
    t = t0 + 1;
    for (int pass = 0; pass < 2; pass++) begin
      bit er;
      er = (pass == 0);
      for (int i = 0; i < NCH; i++) begin
        if (m[i]) begin
          e_busy[t] = 1; e_erase[t] = er;
          e_busy[t+1] = 1; e_erase[t+1] = er; e_own[t+1] = i; e_go[t+1] = 1;
          exp_q.push_back(32'((t + 1) * 16 + int'(er) * 8 + i));
          if (dl[pass][i] == 0) begin
            ex = t + 2 + TMO;
            if (ex + 1 < to_from) to_from = ex + 1;
          end else begin
            ex = t + 1 + dl[pass][i];
            e_done[ex] = 1;
          end
          for (int c = t + 2; c <= ex; c++) begin
            e_busy[c] = 1; e_erase[c] = er; e_own[c] = i;
          end
          t = ex + 1;
        end
      end
      e_busy[t] = 1; e_erase[t] = er;
      if (pass == 0) begin
        e_busy[t+1] = 1;
        exp_q.push_back(32'((t + 1) * 16 + 3));
        for (int c = t + 2; c <= t + 1 + LC; c++) e_busy[c] = 1;
        t = t + 2 + LC;
      end
    end
    return t;
  endfunction

  task automatic check_cycle();
    int o;
    logic [31:0] ev;
    o = e_own[cyc];
    check_eq("busy", 32'(busy), 32'(e_busy[cyc]));
    check_eq("erase", 32'(erase), 32'(e_erase[cyc]));
    check_eq("writeEn", 32'(writeEn), (o >= 0) ? 32'(ch_wren[o]) : 32'd0);
    if (o >= 0) begin
      check_eq("x", 32'(x), 32'(ch_x[o*XW +: XW]));
      check_eq("y", 32'(y), 32'(ch_y[o*YW +: YW]));
      check_eq("colour", 32'(colour), e_erase[cyc] ? 32'(BG) : 32'(ch_colour[o*CW +: CW]));
    end
    check_eq("timeout_err", 32'(timeout_err), 32'(cyc >= to_from));
    check_eq("overrun_err", 32'(overrun_err), 32'(cyc >= ov_from));
    for (int k = 0; k < NCH + 1; k++) begin
      if ((k < NCH) ? ch_go[k] : logic_go) begin
        ev = 32'(cyc * 16 + ((k < NCH) ? int'(erase) * 8 + k : 3));
        if (exp_q.size() == 0) check_eq("ev_extra", ev, 32'hffff_ffff);
        else check_eq("ev_order", ev, exp_q.pop_front());
      end
    end
  endtask

  // driver: inputs change 1 time unit after the edge, outputs checked at negedge
  task automatic step();
    int o;
    @(posedge clk);
    #1;
    cyc++;
    o = e_own[cyc];
    frame_tick = tk[cyc];
    ch_mask = m_set[cyc] ? m_val[cyc] : NCH'($urandom);
    for (int i = 0; i < NCH; i++) begin
      ch_x[i*XW +: XW] = XW'($urandom);
      ch_y[i*YW +: YW] = YW'($urandom);
      ch_colour[i*CW +: CW] = force_col ? '1 : CW'($urandom);
      ch_wren[i] = (cyc == wren_force_cyc) ? 1'b1 : 1'($urandom_range(0, 1));
      if (i == o && !e_go[cyc]) ch_done[i] = e_done[cyc];
      else ch_done[i] = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    check_cycle();
  endtask

  task automatic rand_delays(output int dl[2][NCH], input int dfix, input int hang);
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < NCH; i++)
        dl[p][i] = (i == hang) ? 0 : ((dfix > 0) ? dfix : int'($urandom_range(1, 6)));
  endtask

  task automatic run_frame(input logic [NCH-1:0] m, input int nextra, input int hang, input int dfix);
    int dl[2][NCH];
    int t0, p, pt, ov;
    rand_delays(dl, dfix, hang);
    t0 = cyc + 1;
    tk[t0] = 1; m_set[t0] = 1; m_val[t0] = m;
    p = build_frame(t0, m, dl);
    if (nextra > 0) begin
      pt = int'($urandom_range(t0 + 1, p - 1));
      tk[pt] = 1;
      if (nextra > 1) begin
        ov = int'($urandom_range(pt + 1, p));
        tk[ov] = 1;
        if (ov + 1 < ov_from) ov_from = ov + 1;
      end
      rand_delays(dl, dfix, hang);
      m_set[p+1] = 1; m_val[p+1] = m;
      p = build_frame(p + 1, m, dl);
    end
    while (cyc < p + 3) step();
    check_eq("ev_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic reset_mid_paint();
    int dl[2][NCH];
    int t0, p, rc;
    rand_delays(dl, 6, -1);
    t0 = cyc + 1;
    tk[t0] = 1; m_set[t0] = 1; m_val[t0] = 3'b111;
    p = build_frame(t0, 3'b111, dl);
    rc = -1;
    for (int c = t0; c <= p; c++)
      if (rc < 0 && e_own[c] >= 0 && !e_erase[c] && e_go[c]) rc = c + 3;
    wren_force_cyc = rc;
    while (cyc < rc) step();
    #2;
    reset = 1'b1;
    #1;
    check_eq("rst_writeEn", 32'(writeEn), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_ch_go", 32'(ch_go), 32'd0);
    check_eq("rst_erase", 32'(erase), 32'd0);
    check_eq("rst_timeout_err", 32'(timeout_err), 32'd0);
    check_eq("rst_overrun_err", 32'(overrun_err), 32'd0);
    clear_model(cyc + 1);
    exp_q.delete();
    to_from = NEVER;
    ov_from = NEVER;
    repeat (2) step();
    reset = 1'b0;
    repeat (12) step();
  endtask

  initial begin
    clear_model(0);
    @(negedge clk);
    check_eq("init_busy", 32'(busy), 32'd0);
    check_eq("init_writeEn", 32'(writeEn), 32'd0);
    check_eq("init_ch_go", 32'(ch_go), 32'd0);
    check_eq("init_logic_go", 32'(logic_go), 32'd0);
    check_eq("init_errs", {30'd0, timeout_err, overrun_err}, 32'd0);
    repeat (2) step();
    reset = 1'b0;
    repeat (3) step();

    force_col = 1'b1;
    run_frame(3'b111, 0, -1, 4);
    force_col = 1'b0;
    run_frame(3'b101, 0, -1, 0);
    run_frame(3'b000, 0, -1, 0);
    run_frame(3'b111, 0, 1, 0);
    run_frame(3'b111, 0, -1, 0);
    run_frame(3'b111, 2, -1, 0);
    repeat (25) begin
      run_frame(NCH'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0,
                ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, NCH - 1)) : -1, 0);
    end
    reset_mid_paint();
    run_frame(3'b011, 0, -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
